// File: rtl/arriskv_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding,
// the {pc, instr} packet handed to decode, and the instruction size.
package arriskv_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned IF_ADDR_W   = 32;
  localparam int unsigned IF_INSTR_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } fetch_state_t;

  // Packet at the default widths; the fetch top mirrors this layout with its
  // own parameterised widths.
  typedef struct packed {
    logic [IF_ADDR_W-1:0]  pc;
    logic [IF_INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO between instruction memory and decode.
// Flush empties it in one cycle and dominates push and pop. A push and a
// pop in the same cycle are accepted even when full (occupancy unchanged).
module fetch_fifo #(
  parameter int width = 64,
  parameter int depth = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [width-1:0]             push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [width-1:0]             head_o,
  output logic [$clog2(depth+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(depth - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(depth);

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values
    // regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is cleared on reset only because the head entry drives the
    // decode outputs directly and must read as zero out of reset.
    if (rst) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a
// time and streams {pc, instr} to decode through fetch_fifo. A request is only
// issued when the FIFO is guaranteed room for its response, so backpressure
// never loses a word. Redirects flush the FIFO; a request still in flight at
// the redirect is completed on the memory side and its data discarded.
// Optional: define IFETCH_PERF_CNT_EN to add o_cnt_fetched / o_cnt_stall.
module instr_fetch
  import arriskv_pkg::*;
#(
  parameter int                  wd_instr_p = 32,
  parameter int                  wd_addr_p  = 32,
  parameter int                  depth_p    = 2,
  parameter logic [wd_addr_p-1:0] reset_pc_p = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_imem_req,
  output logic [wd_addr_p-1:0]  o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [wd_instr_p-1:0] i_imem_rdata,
  input  logic                  i_redirect,
  input  logic [wd_addr_p-1:0]  i_redirect_pc,
  output logic                  o_instr_valid,
  output logic [wd_instr_p-1:0] o_instr,
  output logic [wd_addr_p-1:0]  o_pc,
  input  logic                  i_instr_ready
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]           o_cnt_fetched,
  output logic [31:0]           o_cnt_stall
`endif
);

  localparam int PKT_W = wd_addr_p + wd_instr_p;
  localparam int CNT_W = $clog2(depth_p + 1);
  localparam logic [wd_addr_p-1:0] PC_STEP    = wd_addr_p'(INSTR_BYTES);
  localparam logic [wd_addr_p-1:0] ALIGN_MASK = ~wd_addr_p'(INSTR_BYTES - 1);
  localparam logic [CNT_W:0]       DEPTH_OCC  = (CNT_W + 1)'(depth_p);

  typedef struct packed {
    logic [wd_addr_p-1:0]  pc;
    logic [wd_instr_p-1:0] instr;
  } pkt_t;

  fetch_state_t         state_q, state_d;
  logic [wd_addr_p-1:0] pc_q, pc_d;
  logic [wd_addr_p-1:0] addr_q, addr_d;
  logic [wd_addr_p-1:0] redirect_pc;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W:0]       occ_next;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, credit;
  pkt_t                 push_pkt, head_pkt;

  assign redirect_pc = i_redirect_pc & ALIGN_MASK;
  assign pop         = o_instr_valid && i_instr_ready;
  assign push        = (state_q == S_REQ) && i_imem_ack && (!fifo_full || pop);
  assign push_pkt    = '{pc: pc_q, instr: i_imem_rdata};

  fetch_fifo #(
    .width (PKT_W),
    .depth (depth_p)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_pkt),
    .pop_i       (pop),
    .flush_i     (i_redirect),
    .head_o      (head_pkt),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Credit: room for one more response after this cycle's push/pop/flush.
  always_comb begin
    occ_next = {1'b0, fifo_count};
    if (i_redirect) begin
      occ_next = '0;
    end else begin
      if (push) occ_next = occ_next + (CNT_W + 1)'(1);
      if (pop)  occ_next = occ_next - (CNT_W + 1)'(1);
    end
    credit = (occ_next < DEPTH_OCC);
  end

  // Next state, next PC and the address presented to memory.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: if (credit) state_d = S_REQ;
      S_REQ: begin
        if (i_redirect)      state_d = i_imem_ack ? S_IDLE : S_DROP;
        else if (i_imem_ack) state_d = credit ? S_REQ : S_IDLE;
      end
      S_DROP: if (i_imem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (i_redirect)                          pc_d = redirect_pc;
    else if (state_q == S_REQ && i_imem_ack) pc_d = pc_q + PC_STEP;

    // A request being dropped keeps its original address until acknowledged.
    addr_d = (state_d == S_DROP) ? addr_q : pc_d;
  end

  // FSM, PC and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= reset_pc_p;
      addr_q  <= reset_pc_p;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign o_imem_req    = (state_q != S_IDLE);
  assign o_imem_addr   = addr_q;
  assign o_instr_valid = !fifo_empty;
  assign o_pc          = head_pkt.pc;
  assign o_instr       = head_pkt.instr;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] cnt_fetched_q, cnt_stall_q;

  // Pushes that actually land in the FIFO, and cycles with nothing for decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_fetched_q <= '0;
      cnt_stall_q   <= '0;
    end else begin
      if (push && !i_redirect) cnt_fetched_q <= cnt_fetched_q + 32'd1;
      if (!o_instr_valid)      cnt_stall_q   <= cnt_stall_q + 32'd1;
    end
  end

  assign o_cnt_fetched = cnt_fetched_q;
  assign o_cnt_stall   = cnt_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a random phase, all
// checked against a transaction-level scoreboard (expected fetch address
// sequence, queue of packets awaiting delivery) and a memory model whose
// data is address ^ 0xA5A5A5A5.
`timescale 1ns/1ps
module tb_instr_fetch;
  import arriskv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk, rst;
  logic        o_imem_req, i_imem_ack, i_redirect, o_instr_valid, i_instr_ready;
  logic [31:0] o_imem_addr, i_imem_rdata, i_redirect_pc, o_instr, o_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] o_cnt_fetched, o_cnt_stall;
`endif

  instr_fetch #(
    .wd_instr_p (32),
    .wd_addr_p  (32),
    .depth_p    (2),
    .reset_pc_p (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_instr_ready (i_instr_ready)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .o_cnt_fetched (o_cnt_fetched),
    .o_cnt_stall   (o_cnt_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard / memory model state.
  fetch_pkt_t  exp_q[$];
  logic [31:0] exp_fetch;
  bit          stale, prev_hold, prev_rst, armed;
  logic [31:0] prev_addr;
  int          lat_mode, lat_cur, wcnt;
  int          n_deliv, fetched_m, stall_m;
  logic [31:0] last_deliv_pc;
  logic        s_valid, s_req;
  logic [31:0] s_pc, s_instr, s_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_lat();
    return (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
  endfunction

  // One clock cycle: sample at the falling edge, score, then drive inputs.
  task automatic step(input logic r, input logic rdy, input logic redir,
                      input logic [31:0] rpc);
    fetch_pkt_t p;
    bit         kept;
    @(negedge clk);
    s_valid = o_instr_valid;
    s_req   = o_imem_req;
    s_addr  = o_imem_addr;
    s_pc    = o_pc;
    s_instr = o_instr;

    if (armed) begin
      if (prev_rst) begin
        check("rst_req", s_req, 1'b0);
        check("rst_valid", s_valid, 1'b0);
        check("rst_addr", s_addr, RESET_PC);
        check("rst_pc", s_pc, 32'h0);
        check("rst_instr", s_instr, 32'h0);
      end
      check("valid_vs_model", s_valid, exp_q.size() != 0);
      if (s_valid === 1'b1 && exp_q.size() != 0) begin
        check("head_pc", s_pc, exp_q[0].pc);
        check("head_instr", s_instr, exp_q[0].instr);
      end
      if (prev_hold) begin
        check("req_held", s_req, 1'b1);
        check("addr_held", s_addr, prev_addr);
      end
      if (s_req === 1'b1) check("addr_align", s_addr[1:0], 2'b00);
`ifdef IFETCH_PERF_CNT_EN
      check("cnt_fetched", o_cnt_fetched, fetched_m);
      check("cnt_stall", o_cnt_stall, stall_m);
`endif
    end

    rst           = r;
    i_instr_ready = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_imem_ack    = !r && (s_req === 1'b1) && (wcnt >= lat_cur);
    i_imem_rdata  = i_imem_ack ? (s_addr ^ KEY) : $urandom;

    if (r) begin
      exp_q.delete();
      exp_fetch = RESET_PC;
      stale     = 0;
      wcnt      = 0;
      prev_hold = 0;
      fetched_m = 0;
      stall_m   = 0;
      lat_cur   = next_lat();
      armed     = 1;
    end else begin
      kept = 0;
      if (s_valid === 1'b1 && rdy && !redir && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_deliv++;
        last_deliv_pc = s_pc;
      end
      if (i_imem_ack) begin
        if (!redir && !stale) begin
          check("fetch_addr", s_addr, exp_fetch);
          p.pc    = s_addr;
          p.instr = s_addr ^ KEY;
          exp_q.push_back(p);
          exp_fetch = exp_fetch + 32'd4;
          kept = 1;
        end
        stale   = 0;
        wcnt    = 0;
        lat_cur = next_lat();
      end else if (s_req === 1'b1) begin
        wcnt++;
        if (redir) stale = 1;
      end
      if (redir) begin
        exp_q.delete();
        exp_fetch = rpc & ~32'h3;
      end
      prev_hold = (s_req === 1'b1) && !i_imem_ack;
      prev_addr = s_addr;
      if (kept) fetched_m++;
      if (s_valid !== 1'b1) stall_m++;
    end
    prev_rst = r;
  endtask

  task automatic reset_dut();
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    n_deliv = 0;
  endtask

  initial begin
    bit found;
    int fetched_before;
    rst = 1'b1; i_instr_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_imem_ack = 1'b0; i_imem_rdata = '0;
    armed = 0; prev_rst = 0; prev_hold = 0; stale = 0; wcnt = 0;
    lat_mode = 0; lat_cur = 0; n_deliv = 0; fetched_m = 0; stall_m = 0;
    exp_fetch = RESET_PC; prev_addr = '0; last_deliv_pc = '0;

    // 1: zero-wait memory, ready high: one instruction per cycle from cycle 2.
    lat_mode = 0;
    reset_dut();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("t1_c1_valid", s_valid, 1'b0);
    check("t1_c1_req", s_req, 1'b1);
    check("t1_c1_addr", s_addr, RESET_PC);
    for (int n = 2; n <= 5; n++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("t1_valid", s_valid, 1'b1);
      check("t1_pc", s_pc, 32'(4 * (n - 2)));
      check("t1_instr", s_instr, 32'(4 * (n - 2)) ^ KEY);
    end

    // 2 (+6): decode stalls for 6 cycles; FIFO fills with 0,4, no requests.
    reset_dut();
    for (int n = 0; n <= 5; n++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (n >= 3) begin
        check("t2_req_low_full", s_req, 1'b0);
        check("t2_head_pc", s_pc, 32'h0);
        check("t2_valid", s_valid, 1'b1);
      end
    end
    for (int i = 0; i < 20 && n_deliv < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("t2_delivered", n_deliv, 4);
    check("t2_last_pc", last_deliv_pc, 32'd12);
    fetched_before = fetched_m;
    step(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    check("t6_stall", o_cnt_stall, 32'd2);
    check("t6_fetched", o_cnt_fetched, fetched_before);
`endif

    // 3: latency 3, redirect one cycle after the request for 0x8 goes out.
    lat_mode = 3;
    reset_dut();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_req === 1'b1 && s_addr == 32'h8) begin found = 1; break; end
    end
    check("t3_req8_seen", found, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    check("t3_req8_held", s_req, 1'b1);
    check("t3_addr8_held", s_addr, 32'h8);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_valid === 1'b1) begin found = 1; break; end
    end
    check("t3_valid_seen", found, 1'b1);
    check("t3_first_pc", s_pc, 32'h100);

    // 4: redirect to 0x203 together with a pop and an ack.
    lat_mode = 0;
    reset_dut();
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h203);
    check("t4_pop_cycle", s_valid, 1'b1);
    check("t4_ack_cycle", s_req, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_flushed", s_valid, 1'b0);
    check("t4_idle", s_req, 1'b0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_req === 1'b1) begin found = 1; break; end
    end
    check("t4_req_seen", found, 1'b1);
    check("t4_req_addr", s_addr, 32'h200);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_first_pc", s_pc, 32'h200);

    // 5: reset while a request waits for its ack.
    lat_mode = 3;
    reset_dut();
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_req === 1'b1) begin found = 1; break; end
    end
    check("t5_req_waiting", found, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("t5_req_after_rst", s_req, 1'b0);
    check("t5_valid_after_rst", s_valid, 1'b0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_req === 1'b1) begin found = 1; break; end
    end
    check("t5_req_again", found, 1'b1);
    check("t5_req_addr", s_addr, RESET_PC);

    // Random phase: random latency, backpressure and redirects, incl. PC wrap.
    lat_mode = -1;
    reset_dut();
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF6);
    for (int i = 0; i < 800; i++) begin
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom);
    end
    check("rand_progress", n_deliv > 50, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
